// File: rtl/dmem_wait_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_wait_responder_if
// Description : Handshake bundle between the MEM stage (master) and the
//               wait-state data-memory responder (slave).
//               master: drives req_valid/req_we/req_addr/req_wdata and
//                       observes req_ready/rsp_valid/rsp_rdata/rsp_err/stall.
//               slave : the reverse.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_wait_responder_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );
endinterface
`default_nettype wire

// File: rtl/dmem_wait_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_wait_responder
// Description : Data memory for the pipelined MIPS core with a configurable
//               number of wait states. An access is accepted in IDLE, held
//               in BUSY for LATENCY cycles, performed on the last BUSY edge,
//               and answered by a one-cycle rsp_valid pulse in RESP.
//               stall freezes the front of the pipeline until the response.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - dmem_wait_responder_if.slave (request/response/stall)
// Parameters  : DEPTH_WORDS - words in the array (power of two, >= 2)
//               LATENCY     - wait cycles from acceptance to access (1..15)
// Option      : DMEM_MISALIGN_TRAP_EN - when defined, accesses with
//               addr[1:0]!=0 report rsp_err, stores are dropped and loads
//               return zero. When undefined, addr[1:0] is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_wait_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  wire logic              clk,
    input  wire logic              rst,
    dmem_wait_responder_if.slave   bus
);

    localparam int         c_AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [c_AW-1:0]   r_idx;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic [31:0]       r_mem [DEPTH_WORDS];

    logic              w_accept;
    logic              w_fire;
    logic              w_misalign;
    logic              w_mem_we;
    logic              w_unused;

`ifdef DMEM_MISALIGN_TRAP_EN
    logic [1:0]        r_lo;
    assign w_misalign = (r_lo != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // Address bits outside the word index are intentionally ignored.
    assign w_unused = &{1'b0, bus.req_addr};

    assign w_accept = (r_state == S_IDLE) && bus.req_valid;
    // The access happens on the last BUSY edge, from the captured copies only.
    assign w_fire   = (r_state == S_BUSY) && (r_cnt == 4'd0);
    // The async reset forces r_state to IDLE, so an in-flight store can never
    // commit while rst is high.
    assign w_mem_we = w_fire && r_we && !w_misalign;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.req_valid) w_next_state = S_BUSY;
            S_BUSY:  if (r_cnt == 4'd0) w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, counter, holding and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_idx   <= bus.req_addr[c_AW+1:2];
                r_wdata <= bus.req_wdata;
                r_cnt   <= c_CNT_INIT;
            end else if ((r_state == S_BUSY) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_fire) begin
                r_err <= w_misalign;
                if (r_we || w_misalign) begin
                    r_rdata <= 32'd0;
                end else begin
                    r_rdata <= r_mem[r_idx];
                end
            end
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lo <= 2'b00;
        end else if (w_accept) begin
            r_lo <= bus.req_addr[1:0];
        end
    end
`endif

    // Word array: no reset, contents survive rst.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
    // Drops in the RESP cycle so the pipeline advances with the response.
    assign bus.stall     = bus.req_valid && (r_state != S_RESP);

endmodule
`default_nettype wire

// File: tb/tb_dmem_wait_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_wait_responder
// Description : Self-checking bench for dmem_wait_responder. Instance u_dut
//               uses LATENCY=3, u_dut1 uses LATENCY=1 for back-to-back timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_wait_responder;

    localparam int c_LAT   = 3;
    localparam int c_DEPTH = 256;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit c_TRAP = 1'b1;
`else
    localparam bit c_TRAP = 1'b0;
`endif

    logic clk;
    logic rst;

    dmem_wait_responder_if bus0 ();
    dmem_wait_responder_if bus1 ();

    dmem_wait_responder #(.DEPTH_WORDS(c_DEPTH), .LATENCY(c_LAT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    dmem_wait_responder #(.DEPTH_WORDS(c_DEPTH), .LATENCY(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference memory: word-addressed, address taken modulo the depth.
    logic [31:0] model_mem [c_DEPTH];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: what an access should return, and its effect.
    task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err);
        int idx;
        bit mis;
        idx = int'((addr >> 2) % c_DEPTH);
        mis = c_TRAP && (addr % 4 != 0);
        err = mis;
        if (mis) begin
            rdata = 32'd0;
        end else if (we) begin
            model_mem[idx] = wdata;
            rdata = 32'd0;
        end else begin
            rdata = model_mem[idx];
        end
    endtask

    // One access on bus0, checking handshake timing; returns response data.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic err);
        int n;
        int stall_cnt;
        bit got;
        @(negedge clk);
        bus0.req_we    = we;
        bus0.req_addr  = addr;
        bus0.req_wdata = wdata;
        bus0.req_valid = 1'b1;
        #1;
        check("ready_before_accept", 32'(bus0.req_ready), 32'd1);
        check("stall_on_request", 32'(bus0.stall), 32'd1);
        @(posedge clk);
        n = 0;
        stall_cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (bus0.rsp_valid) begin
                got = 1'b1;
                break;
            end
            if (bus0.stall) stall_cnt++;
            @(posedge clk);
            n++;
        end
        check("rsp_seen", 32'(got), 32'd1);
        check("rsp_latency", 32'(n), 32'(c_LAT));
        check("stall_cycles", 32'(stall_cnt), 32'(c_LAT));
        check("stall_low_in_rsp", 32'(bus0.stall), 32'd0);
        rdata = bus0.rsp_rdata;
        err   = bus0.rsp_err;
        bus0.req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rsp_pulse_width", 32'(bus0.rsp_valid), 32'd0);
        check("ready_after_rsp", 32'(bus0.req_ready), 32'd1);
    endtask

    task automatic model_checked_access(input string name, input logic we,
                                        input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] exp_rd, act_rd;
        logic exp_err, act_err;
        model_access(we, addr, wdata, exp_rd, exp_err);
        do_access(we, addr, wdata, act_rd, act_err);
        check({name, "_rdata"}, act_rd, exp_rd);
        check({name, "_err"}, 32'(act_err), 32'(exp_err));
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          pos [$];
        int          nrsp;

        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0,         1'b0};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'd0,         32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0400, 32'h0000_0001, 32'd0,         1'b0};
        vecs[3] = '{1'b0, 32'h0000_0000, 32'd0,         32'h0000_0001, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_0013, 32'hCAFE_F00D, 32'd0,         c_TRAP};
        vecs[5] = '{1'b0, 32'h0000_0010, 32'd0,
                    c_TRAP ? 32'hDEAD_BEEF : 32'hCAFE_F00D,            1'b0};
        vecs[6] = '{1'b0, 32'h0000_0013, 32'd0,
                    c_TRAP ? 32'd0 : 32'hCAFE_F00D,                    c_TRAP};
        vecs[7] = '{1'b0, 32'h8000_0010, 32'd0,
                    c_TRAP ? 32'hDEAD_BEEF : 32'hCAFE_F00D,            1'b0};

        rst = 1'b1;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
        bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        check("reset_rsp_rdata", bus0.rsp_rdata, 32'd0);
        check("reset_rsp_err", 32'(bus0.rsp_err), 32'd0);
        check("reset_stall", 32'(bus0.stall), 32'd0);
        check("reset_ready", 32'(bus0.req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Give every word a known value so later loads are fully predictable.
        for (int i = 0; i < c_DEPTH; i++) begin
            model_checked_access("init", 1'b1, 32'(i * 4), $urandom);
        end

        // Directed vectors.
        for (int i = 0; i < 8; i++) begin
            logic [31:0] mrd;
            logic merr;
            model_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, mrd, merr);
            do_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
        end

        // Reset while a store is waiting: it must vanish without a response.
        model_checked_access("pre_abort_load", 1'b0, 32'h0000_0010, 32'd0);
        @(negedge clk);
        bus0.req_we    = 1'b1;
        bus0.req_addr  = 32'h0000_0020;
        bus0.req_wdata = 32'h0000_0055;
        bus0.req_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3;
        bus0.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("async_rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        check("async_rst_rsp_rdata", bus0.rsp_rdata, 32'd0);
        check("async_rst_rsp_err", 32'(bus0.rsp_err), 32'd0);
        check("async_rst_stall", 32'(bus0.stall), 32'd0);
        check("async_rst_ready", 32'(bus0.req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        nrsp = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus0.rsp_valid) nrsp++;
        end
        check("abort_no_rsp", 32'(nrsp), 32'd0);
        model_checked_access("abort_load", 1'b0, 32'h0000_0020, 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            model_checked_access("rand", 1'(($urandom_range(0, 1))), a, $urandom);
        end

        // LATENCY=1, request held high: one acceptance every 3 cycles.
        @(negedge clk);
        bus1.req_we    = 1'b1;
        bus1.req_addr  = 32'h0000_0040;
        bus1.req_wdata = 32'h1234_5678;
        bus1.req_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (bus1.rsp_valid) pos.push_back(i);
        end
        bus1.req_valid = 1'b0;
        check("b2b_pulse_count", 32'(pos.size()), 32'd10);
        for (int i = 1; i < pos.size(); i++) begin
            check("b2b_period", 32'(pos[i] - pos[i-1]), 32'd3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
